// File: rtl/sr_pkg.sv
// Shared definitions for the SR command sequencer: FSM state encoding, op constants, counter width.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } sr_state_t;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

  // Wide enough for PULSE_W and GAP_W up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/sr_cmd_fifo.sv
// Synchronous 1-bit command FIFO. DEPTH is a power of two, so the pointers wrap modulo DEPTH
// simply by overflowing. A push while full and a pop while empty are both ignored.
module sr_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   din,
  output logic                   dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == (AW+1)'(DEPTH));
  assign empty  = (count_r == (AW+1)'(0));
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign dout   = mem_r[rd_ptr_r];
  assign count  = count_r;

  // Storage, pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r    <= {DEPTH{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Queues set/reset commands and replays them as non-overlapping S/R pulses to an SR flip-flop.
// Optional readback check of the flip-flop output is enabled by defining SR_READBACK_CHECK_EN.
module sr_cmd_sequencer
  import sr_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic                   req_op,
  output logic                   req_ready,
  output logic                   S,
  output logic                   R,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
`ifdef SR_READBACK_CHECK_EN
  ,
  input  logic                   q_in,
  output logic                   err
`endif
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_W > 0) ? (GAP_W - 1) : 0);

  sr_state_t        state_r;
  sr_state_t        state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             op_r;
  logic             op_s;
  logic             s_next_s;
  logic             r_next_s;
  logic             launch_s;
  logic             pop_s;
  logic             push_s;
  logic             head_s;
  logic             full_s;
  logic             empty_s;

  assign push_s    = req_valid && !full_s;
  assign req_ready = !full_s;
  assign busy      = (state_r != IDLE) || !empty_s;

  sr_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (req_op),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count)
  );

  // Next-state logic. Whenever a phase ends in IDLE with a command waiting, the next pulse
  // launches on the same edge so back-to-back pulses are spaced by exactly the gap.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    op_s     = op_r;
    s_next_s = S;
    r_next_s = R;
    launch_s = 1'b0;
    pop_s    = 1'b0;
    case (state_r)
      IDLE: begin
        launch_s = !empty_s;
      end
      PULSE: begin
        if (cnt_r == PULSE_LAST) begin
          s_next_s = 1'b0;
          r_next_s = 1'b0;
          cnt_s    = {CNT_W{1'b0}};
`ifdef SR_READBACK_CHECK_EN
          state_s  = CHECK;
`else
          if (GAP_W > 0) begin
            state_s = GAP;
          end else begin
            state_s  = IDLE;
            launch_s = !empty_s;
          end
`endif
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
`ifdef SR_READBACK_CHECK_EN
      CHECK: begin
        if (GAP_W > 0) begin
          state_s = GAP;
        end else begin
          state_s  = IDLE;
          launch_s = !empty_s;
        end
      end
`endif
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_s  = IDLE;
          launch_s = !empty_s;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s  = IDLE;
        cnt_s    = {CNT_W{1'b0}};
        s_next_s = 1'b0;
        r_next_s = 1'b0;
      end
    endcase
    if (launch_s) begin
      pop_s    = 1'b1;
      state_s  = PULSE;
      cnt_s    = {CNT_W{1'b0}};
      op_s     = head_s;
      s_next_s = head_s;
      r_next_s = !head_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  // State, counter and registered S/R drive; reset drops S/R immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      op_r    <= OP_RESET;
      S       <= 1'b0;
      R       <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      op_r    <= op_s;
      S       <= s_next_s;
      R       <= r_next_s;
    end
  end

`ifdef SR_READBACK_CHECK_EN
  // Sticky readback error: Q must match the op just issued while in CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((state_r == CHECK) && (q_in != op_r)) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end
`endif

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Randomized and directed bench for sr_cmd_sequencer; three instances cover the default,
// a long-pulse configuration (FIFO fill) and PULSE_W=1/GAP_W=0.
module tb_sr_cmd_sequencer;

`ifdef SR_READBACK_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] vld;
  logic [2:0] opb;
  logic [2:0] qin;
  logic [2:0] bad;
  logic [2:0] ds;
  logic [2:0] dr;
  logic [2:0] dbusy;
  logic [2:0] drdy;
  logic [2:0] derr;
  logic [2:0] dcnt [3];

  int n_cmp;
  int n_bad;

  // Reference model: queue of pending ops plus the schedule of the current pulse.
  int ecnt;
  int pw [3] = '{2, 12, 1};
  int gw [3] = '{1, 1, 0};
  int qh [3];
  int qt [3];
  int ps [3];
  int pe [3];
  int fe [3];
  bit pop_op [3];
  bit merr [3];
  bit qm [3][64];

  sr_cmd_sequencer #(.DEPTH(4), .PULSE_W(2), .GAP_W(1)) dut0 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_op(opb[0]), .req_ready(drdy[0]),
    .S(ds[0]), .R(dr[0]), .busy(dbusy[0]), .count(dcnt[0])
`ifdef SR_READBACK_CHECK_EN
    , .q_in(qin[0]), .err(derr[0])
`endif
  );

  sr_cmd_sequencer #(.DEPTH(4), .PULSE_W(12), .GAP_W(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_op(opb[1]), .req_ready(drdy[1]),
    .S(ds[1]), .R(dr[1]), .busy(dbusy[1]), .count(dcnt[1])
`ifdef SR_READBACK_CHECK_EN
    , .q_in(qin[1]), .err(derr[1])
`endif
  );

  sr_cmd_sequencer #(.DEPTH(4), .PULSE_W(1), .GAP_W(0)) dut2 (
    .clk(clk), .rst(rst), .req_valid(vld[2]), .req_op(opb[2]), .req_ready(drdy[2]),
    .S(ds[2]), .R(dr[2]), .busy(dbusy[2]), .count(dcnt[2])
`ifdef SR_READBACK_CHECK_EN
    , .q_in(qin[2]), .err(derr[2])
`endif
  );

`ifndef SR_READBACK_CHECK_EN
  assign derr = 3'b000;
`endif

  always #5 clk = ~clk;

  task automatic model_reset(int k);
    qh[k] = qt[k];
    ps[k] = ecnt;
    pe[k] = ecnt;
    fe[k] = ecnt;
    merr[k] = 1'b0;
  endtask

  task automatic model_edge(int k, bit v, bit op, bit q);
    int sz;
    sz = qt[k] - qh[k];
    if (CHK == 1 && ps[k] != pe[k] && ecnt == pe[k] + 1 && q != pop_op[k]) merr[k] = 1'b1;
    if (sz > 0 && ecnt >= fe[k]) begin
      pop_op[k] = qm[k][qh[k] % 64];
      qh[k]++;
      ps[k] = ecnt;
      pe[k] = ecnt + pw[k];
      fe[k] = pe[k] + CHK + gw[k];
    end
    if (v && sz < 4) begin
      qm[k][qt[k] % 64] = op;
      qt[k]++;
    end
  endtask

  function automatic logic [6:0] exp_vec(int k);
    int sz;
    bit act;
    sz  = qt[k] - qh[k];
    act = (ecnt >= ps[k]) && (ecnt < pe[k]);
    return {act && pop_op[k], act && !pop_op[k], (sz > 0) || (ecnt < fe[k]), sz < 4, 3'(sz)};
  endfunction

  function automatic logic [6:0] obs_vec(int k);
    return {ds[k], dr[k], dbusy[k], drdy[k], dcnt[k]};
  endfunction

  task automatic tick();
    @(posedge clk);
    ecnt++;
    for (int k = 0; k < 3; k++) begin
      if (rst) model_reset(k);
      else model_edge(k, vld[k], opb[k], qin[k]);
    end
    #1;
    for (int k = 0; k < 3; k++) qin[k] = bad[k] ? 1'b0 : pop_op[k];
  endtask

  task automatic test_reset();
    #3;
    for (int k = 0; k < 3; k++) model_reset(k);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs_vec(k) !== 7'b0001000 || derr[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset inst%0d: got %b err=%b, want 0001000 err=0", k, obs_vec(k), derr[k]);
      end
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_set();
    logic [4:0] s_seen;
    vld[0] = 1'b1; opb[0] = 1'b1;
    tick();
    vld[0] = 1'b0; opb[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      s_seen[4-i] = ds[0];
      n_cmp++;
      if (obs_vec(0) !== exp_vec(0)) begin
        n_bad++;
        $display("FAIL single_set cyc%0d: got %b, want %b", i, obs_vec(0), exp_vec(0));
      end
    end
    n_cmp++;
    if (s_seen !== 5'b11000 || dbusy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL single_set_shape: S trace %b busy=%b, want 11000 busy=0", s_seen, dbusy[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq;
    int np;
    bit prev;
    seq = 3'b101;
    np = 0;
    prev = 1'b0;
    for (int i = 0; i < 14; i++) begin
      vld[0] = (i < 3);
      opb[0] = (i < 3) ? seq[2-i] : 1'b0;
      tick();
      n_cmp++;
      if (obs_vec(0) !== exp_vec(0) || (ds[0] & dr[0])) begin
        n_bad++;
        $display("FAIL back_to_back cyc%0d: got %b, want %b", i, obs_vec(0), exp_vec(0));
      end
      if ((ds[0] | dr[0]) && !prev && np < 3) begin
        n_cmp++;
        if (ds[0] !== seq[2-np]) begin
          n_bad++;
          $display("FAIL b2b_order pulse%0d: got S=%b, want S=%b", np, ds[0], seq[2-np]);
        end
        np++;
      end
      prev = ds[0] | dr[0];
    end
    vld[0] = 1'b0;
    n_cmp++;
    if (np != 3) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d pulses, want 3", np);
    end
  endtask

  task automatic test_full();
    logic [5:0] cmds;
    int np;
    bit prev;
    cmds = 6'b101100;
    np = 0;
    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vld[1] = 1'b1;
      opb[1] = cmds[5-i];
      tick();
      if (i == 4) begin
        n_cmp++;
        if (drdy[1] !== 1'b0 || dcnt[1] !== 3'd4) begin
          n_bad++;
          $display("FAIL full_ready: got ready=%b count=%0d, want ready=0 count=4", drdy[1], dcnt[1]);
        end
      end
      if ((ds[1] | dr[1]) && !prev) np++;
      prev = ds[1] | dr[1];
    end
    vld[1] = 1'b0;
    n_cmp++;
    if (dcnt[1] !== 3'd4 || obs_vec(1) !== exp_vec(1)) begin
      n_bad++;
      $display("FAIL full_drop: got %b, want count=4 (%b)", obs_vec(1), exp_vec(1));
    end
    for (int i = 0; i < 120 && dbusy[1]; i++) begin
      tick();
      n_cmp++;
      if (obs_vec(1) !== exp_vec(1)) begin
        n_bad++;
        $display("FAIL full_drain cyc%0d: got %b, want %b", i, obs_vec(1), exp_vec(1));
      end
      if ((ds[1] | dr[1]) && !prev) begin
        n_cmp++;
        if (np < 5 && ds[1] !== cmds[5-np]) begin
          n_bad++;
          $display("FAIL full_order pulse%0d: got S=%b, want S=%b", np, ds[1], cmds[5-np]);
        end
        np++;
      end
      prev = ds[1] | dr[1];
    end
    n_cmp++;
    if (np != 5 || dbusy[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL full_pulses: got %0d pulses busy=%b, want 5 busy=0", np, dbusy[1]);
    end
  endtask

  task automatic test_reset_mid_pulse();
    vld[0] = 1'b1; opb[0] = 1'b0;
    tick();
    opb[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    n_cmp++;
    if (dr[0] !== 1'b1 || dcnt[0] !== 3'd1) begin
      n_bad++;
      $display("FAIL midrst_pre: got R=%b count=%0d, want R=1 count=1", dr[0], dcnt[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) model_reset(k);
    n_cmp++;
    if (obs_vec(0) !== 7'b0001000) begin
      n_bad++;
      $display("FAIL midrst_async: got %b, want 0001000", obs_vec(0));
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (obs_vec(0) !== exp_vec(0) || ds[0] !== 1'b0 || dr[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL midrst_quiet cyc%0d: got %b, want %b", i, obs_vec(0), exp_vec(0));
      end
    end
  endtask

  task automatic test_gap0();
    logic [1:0] sr_trace [3];
    vld[2] = 1'b1; opb[2] = 1'b0;
    tick();
    opb[2] = 1'b1;
    tick();
    sr_trace[0] = {ds[2], dr[2]};
    vld[2] = 1'b0;
    for (int i = 1; i < 3; i++) begin
      tick();
      sr_trace[i] = {ds[2], dr[2]};
      n_cmp++;
      if (obs_vec(2) !== exp_vec(2)) begin
        n_bad++;
        $display("FAIL gap0 cyc%0d: got %b, want %b", i, obs_vec(2), exp_vec(2));
      end
    end
`ifndef SR_READBACK_CHECK_EN
    n_cmp++;
    if (sr_trace[0] !== 2'b01 || sr_trace[1] !== 2'b10 || sr_trace[2] !== 2'b00) begin
      n_bad++;
      $display("FAIL gap0_shape: got SR %b %b %b, want 01 10 00", sr_trace[0], sr_trace[1], sr_trace[2]);
    end
`endif
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 3; k++) begin
        vld[k] = ($urandom_range(0, 9) < 4);
        opb[k] = 1'($urandom_range(0, 1));
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs_vec(k) !== exp_vec(k) || (ds[k] & dr[k]) || derr[k] !== merr[k]) begin
          n_bad++;
          $display("FAIL random inst%0d cyc%0d: got %b err=%b, want %b err=%b",
                   k, i, obs_vec(k), derr[k], exp_vec(k), merr[k]);
        end
      end
    end
    vld = 3'b000;
    for (int i = 0; i < 80; i++) tick();
  endtask

`ifdef SR_READBACK_CHECK_EN
  task automatic test_readback();
    bad[0] = 1'b1;
    vld[0] = 1'b1; opb[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++;
    if (derr[0] !== 1'b1 || merr[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL readback_set: got err=%b, want 1", derr[0]);
    end
    bad[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      vld[0] = (i < 2); opb[0] = (i == 0);
      tick();
      n_cmp++;
      if (derr[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL readback_sticky cyc%0d: got err=%b, want 1", i, derr[0]);
      end
    end
    vld[0] = 1'b0;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) model_reset(k);
    n_cmp++;
    if (derr[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL readback_clear: got err=%b, want 0", derr[0]);
    end
    tick();
    rst = 1'b0;
  endtask
`endif

  initial begin
    clk = 1'b0; rst = 1'b1;
    vld = 3'b000; opb = 3'b000; qin = 3'b000; bad = 3'b000;
    n_cmp = 0; n_bad = 0; ecnt = 0;
    for (int k = 0; k < 3; k++) begin
      qh[k] = 0; qt[k] = 0; pop_op[k] = 1'b0;
    end
    test_reset();
    test_single_set();
    test_back_to_back();
    test_full();
    test_reset_mid_pulse();
    test_gap0();
`ifdef SR_READBACK_CHECK_EN
    test_readback();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sr_cmd_sequencer.md
SR_CMD_SEQUENCER -- requirements
Module: sr_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter PULSE_W, default 2, meaning clock cycles S or R is held high per command (1..15).
REQ-003 SHALL have parameter GAP_W, default 1, meaning idle cycles with S=R=0 between consecutive pulses (0..15).
REQ-004 SHALL have port clk, input, 1, meaning the single clock, rising-edge active.
REQ-005 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, meaning a command is offered.
REQ-007 SHALL have port req_op, input, 1, meaning 1=set and 0=reset, qualified by req_valid.
REQ-008 SHALL have port req_ready, output, 1, meaning the FIFO can accept a command this cycle.
REQ-009 SHALL have port S, output, 1, meaning registered set drive to the downstream SR flip-flop.
REQ-010 SHALL have port R, output, 1, meaning registered reset drive to the downstream SR flip-flop.
REQ-011 SHALL have port busy, output, 1, meaning the FSM is not IDLE or the FIFO is non-empty.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1, meaning the current FIFO occupancy.
REQ-013 SHALL, with SR_READBACK_CHECK_EN only, have port q_in, input, 1, meaning flip-flop Q fed back, and port err, output, 1, meaning sticky readback mismatch.

Function
REQ-014 SHALL accept a command on a rising edge with req_valid=1 and req_ready=1, and req_ready SHALL equal (count<DEPTH) with no full-bypass.
REQ-015 SHALL preserve command order, and the FIFO read/write pointers SHALL wrap modulo DEPTH.
REQ-016 SHALL implement FSM states IDLE, PULSE, GAP and, with the macro only, CHECK.
REQ-017 SHALL pop the head entry in IDLE with count>0, enter PULSE, and drive S=req_op and R=~req_op for exactly PULSE_W cycles.
REQ-018 SHALL, for a command accepted at edge N into an empty FIFO with the FSM in IDLE, pop it at edge N+1 and drive S or R high from edge N+1.
REQ-019 SHALL, after PULSE, enter CHECK for 1 cycle when the macro is defined, then GAP for GAP_W cycles, then return to IDLE; with GAP_W=0, GAP SHALL be skipped.
REQ-020 SHALL never assert S and R in the same cycle, in any state, during reset, or after reset.
REQ-021 SHALL, on a push and pop on the same edge, leave count unchanged; a push while full SHALL be ignored and leave FIFO contents intact.
REQ-022 SHALL ignore req_op whenever req_valid=0.

Reset
REQ-023 SHALL, on rst high, immediately clear S, R, count, the pointers and err, and force the FSM to IDLE, with req_ready=1 and busy=0.
REQ-024 SHALL, when reset is asserted mid-pulse, drop S or R asynchronously, discard the command, and not replay it.

Configuration
REQ-025 SHALL treat SR_READBACK_CHECK_EN as the single configuration macro.
REQ-026 SHALL, with SR_READBACK_CHECK_EN defined, in CHECK compare q_in to the op just issued and set err on mismatch, with err held until rst.
REQ-027 SHALL, with SR_READBACK_CHECK_EN undefined, omit the q_in and err ports and the CHECK state, and go directly from PULSE to GAP.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, PULSE, GAP, CHECK) and the OP_SET=1/OP_RESET=0 constants in shared package sr_pkg.
REQ-029 SHALL implement the FIFO as sub-module sr_cmd_fifo (synchronous, parameter DEPTH, width 1), with the FSM and pulse/gap counters in the top module.

Verification
REQ-030 SHALL verify single set: push op=1 at edge 0 with defaults -> S=1 for edges 1..2, S=R=0 from edge 3, R=0 throughout, busy=0 after GAP.
REQ-031 SHALL verify back-to-back traffic: push 1,0,1 on consecutive edges -> pulse order S,R,S, each 2 cycles, 1 idle cycle between pulses, never S&R.
REQ-032 SHALL verify full FIFO: push 5 commands with DEPTH=4 while the FSM is stalled in the first pulse -> req_ready=0 at count=4, 5th push dropped, 4 pulses emitted.
REQ-033 SHALL verify reset mid-pulse: assert rst during R high -> R=0 immediately, count=0, and no pulse after rst release until a new push.
REQ-034 SHALL verify readback (macro defined): after a set command, hold q_in=0 in CHECK -> err=1 and held across later good commands until rst.
REQ-035 SHALL verify GAP_W=0 with PULSE_W=1: push 0,1 -> R high 1 cycle, then S high the next cycle with no idle gap.
